// File: rtl/sig16b_to_double_pkg.sv
// Shared definitions for the sign-magnitude <-> FP64 converters.
package sig16b_to_double_pkg;

   localparam int FP64_W       = 64;
   localparam int SIGN_BIT     = 63;
   localparam int EXP_MSB      = 62;
   localparam int EXP_LSB      = 52;
   localparam int EXP_W        = EXP_MSB - EXP_LSB + 1;
   localparam int FRAC_W       = 52;
   localparam int EXP_BIAS     = 1023;
   localparam int SIG16B_W     = 16;
   localparam int SIG16B_MAG_W = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   function automatic logic [FP64_W-1:0] pack_fp64(input logic              i_sign,
                                                   input logic [EXP_W-1:0]  i_exp,
                                                   input logic [FRAC_W-1:0] i_frac);
      return {i_sign, i_exp, i_frac};
   endfunction

endpackage

// File: rtl/sig16b_to_double_if.sv
// Valid/ready sample input and FP64 result output of the converter.
interface sig16b_to_double_if;
   import sig16b_to_double_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [SIG16B_W-1:0] sig16b;
   logic                out_valid;
   logic                out_ready;
   logic [FP64_W-1:0]   double;

   modport slave (
      input  in_valid, sig16b, out_ready,
      output in_ready, out_valid, double
   );

   modport master (
      output in_valid, sig16b, out_ready,
      input  in_ready, out_valid, double
   );
endinterface

// File: rtl/sig16b_to_double.sv
// Exact 16-bit sign-magnitude to IEEE-754 double converter.
// Normalises one bit per cycle: the magnitude shifts left until its top bit is
// set, decrementing the exponent each step, then the result is packed.
//
//  state | meaning
//  IDLE  | ready for a sample, in_ready high
//  NORM  | shifting magnitude toward bit 14
//  OUT   | result presented, waiting for out_ready
module sig16b_to_double
   import sig16b_to_double_pkg::*;
#(
   parameter int EXP_BIAS    = sig16b_to_double_pkg::EXP_BIAS,
   parameter bit ZERO_SIGNED = 1'b1
) (
   input  logic               clk_sampling,
   input  logic               rst,
   sig16b_to_double_if.slave  bus
);

   localparam logic [EXP_W-1:0] EXP_START = EXP_W'(EXP_BIAS + SIG16B_MAG_W - 1);
   localparam int               FRAC_PAD  = FRAC_W - (SIG16B_MAG_W - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [SIG16B_MAG_W-1:0] r_mag;
   logic [EXP_W-1:0]        r_exp;
   logic                    r_sign;
   logic [FP64_W-1:0]       r_double;
   logic                    w_mag_zero;
   logic                    w_mag_norm;

   assign w_mag_zero = (r_mag == '0);
   assign w_mag_norm = r_mag[SIG16B_MAG_W-1];

   // State register.
   always_ff @(posedge clk_sampling or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.in_valid)              w_state_nxt = ST_NORM;
         ST_NORM: if (w_mag_zero || w_mag_norm)  w_state_nxt = ST_OUT;
         ST_OUT:  if (bus.out_ready)             w_state_nxt = ST_IDLE;
         default:                                w_state_nxt = ST_IDLE;
      endcase
   end

   // Capture, shift/decrement while normalising, and pack the result.
   always_ff @(posedge clk_sampling or posedge rst) begin
      if (rst) begin
         r_mag    <= '0;
         r_exp    <= '0;
         r_sign   <= 1'b0;
         r_double <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_sign <= bus.sig16b[SIG16B_W-1];
                  r_mag  <= bus.sig16b[SIG16B_MAG_W-1:0];
                  r_exp  <= EXP_START;
               end
            end
            ST_NORM: begin
               if (w_mag_zero) begin
                  r_double <= {(ZERO_SIGNED ? r_sign : 1'b0), {(FP64_W-1){1'b0}}};
               end else if (w_mag_norm) begin
                  // Hidden bit dropped; the exponent cannot underflow since the
                  // loop stops once bit 14 is set.
                  r_double <= pack_fp64(r_sign, r_exp,
                                        {r_mag[SIG16B_MAG_W-2:0], {FRAC_PAD{1'b0}}});
               end else begin
                  r_mag <= {r_mag[SIG16B_MAG_W-2:0], 1'b0};
                  r_exp <= r_exp - EXP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_OUT);
   assign bus.double    = r_double;

endmodule

// File: tb/tb_sig16b_to_double.sv
// Testbench for sig16b_to_double: directed vectors, backpressure, async reset,
// then random samples, checked against a real-arithmetic reference model.
module tb_sig16b_to_double;

   logic clk_sampling = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_sampling = ~clk_sampling;

   sig16b_to_double_if bus ();
   sig16b_to_double_if bus_z ();

   assign bus_z.in_valid  = bus.in_valid;
   assign bus_z.sig16b    = bus.sig16b;
   assign bus_z.out_ready = bus.out_ready;

   sig16b_to_double #(.ZERO_SIGNED(1'b1)) dut (
      .clk_sampling (clk_sampling),
      .rst          (rst),
      .bus          (bus)
   );

   sig16b_to_double #(.ZERO_SIGNED(1'b0)) dut_z (
      .clk_sampling (clk_sampling),
      .rst          (rst),
      .bus          (bus_z)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: value of the sample as a real, converted by the simulator.
   function automatic logic [63:0] model(input logic [15:0] s, input bit zs);
      int unsigned m;
      real         v;
      m = 32'(s[14:0]);
      if (m == 0) return {zs & s[15], 63'h0};
      v = real'(m);
      if (s[15]) v = -v;
      return $realtobits(v);
   endfunction

   function automatic int lead_zeros(input logic [15:0] s);
      int p;
      p = -1;
      for (int i = 0; i < 15; i++) if (s[i]) p = i;
      return (p < 0) ? 0 : 14 - p;
   endfunction

   task automatic convert(input logic [15:0] s, input logic [63:0] want,
                          input int stall, input bit poke, input logic [15:0] s2);
      logic [63:0] exp0;
      int n;
      exp0 = model(s, 1'b0);
      @(negedge clk_sampling);
      chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.sig16b   = s;
      @(posedge clk_sampling);
      #1;
      bus.in_valid = 1'b0;
      bus.sig16b   = 16'($urandom);
      chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk_sampling);
         #1;
         n++;
      end
      chk("latency", 64'(n), 64'(lead_zeros(s) + 1));
      chk("double", bus.double, want);
      chk("double_zs0", bus_z.double, exp0);
      chk("out_valid_zs0", 64'(bus_z.out_valid), 64'd1);
      for (int k = 0; k < stall; k++) begin
         @(negedge clk_sampling);
         if (poke) begin
            bus.in_valid = 1'b1;
            bus.sig16b   = s2;
         end
         @(posedge clk_sampling);
         #1;
         chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
         chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
         chk("stall_double", bus.double, want);
      end
      @(negedge clk_sampling);
      bus.out_ready = 1'b1;
      @(posedge clk_sampling);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("handoff_out_valid", 64'(bus.out_valid), 64'd0);
      chk("handoff_in_ready", 64'(bus.in_ready), 64'd1);
      chk("handoff_retain", bus.double, want);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] s;
      logic [15:0] s2;
      int          st;
      bit          pk;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.sig16b    = 16'h0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_double", bus.double, 64'h0);
      @(negedge clk_sampling);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      convert(16'h0001, 64'h3FF0000000000000, 0, 1'b0, 16'h0);
      convert(16'h7FFF, 64'h40DFFFC000000000, 1, 1'b0, 16'h0);
      convert(16'h8003, 64'hC008000000000000, 0, 1'b0, 16'h0);
      convert(16'h8000, 64'h8000000000000000, 0, 1'b0, 16'h0);
      convert(16'h0000, 64'h0000000000000000, 0, 1'b0, 16'h0);
      convert(16'h1234, 64'h40B2340000000000, 5, 1'b1, 16'h0A0B);
      convert(16'h0A0B, 64'h40A4160000000000, 0, 1'b0, 16'h0);

      // Async reset in the middle of normalisation.
      @(negedge clk_sampling);
      bus.in_valid = 1'b1;
      bus.sig16b   = 16'h0001;
      @(posedge clk_sampling);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk_sampling);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_double", bus.double, 64'h0);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk_sampling);
      rst = 1'b0;
      repeat (2) @(posedge clk_sampling);
      #1;
      chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);
      convert(16'h0040, 64'h4050000000000000, 0, 1'b0, 16'h0);

      for (int i = 0; i < 30; i++) begin
         s  = 16'($urandom);
         if (i % 7 == 0) s[14:0] = 15'(s[14:0] >> $urandom_range(8, 14));
         s2 = 16'($urandom);
         st = $urandom_range(0, 2);
         pk = (st > 0) && ($urandom_range(0, 1) == 1);
         convert(s, model(s, 1'b1), st, pk, s2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
